cov_matrix_streamer: RTL and testbench
======================================

Name: cov_matrix_streamer

Overview:
Downstream neighbour of the 4-channel covariance accumulator in the MUSIC array chain. It captures each completed 4x4 covariance frame on a one-cycle strobe. It applies optional diagonal loading with signed saturation, and holds the frame in a two-bank buffer. It then streams the 10 unique upper-triangular entries over a valid/ready interface to the eigen-decomposition stage, and counts frames lost to back-pressure.

Parameters:
DIAG_LOAD, 0, signed 32-bit value added to diagonal entries (R00, R11, R22, R33) at capture
DROP_W, 16, width of saturating dropped-frame counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cov_valid  in  1  one-cycle strobe per completed frame; the producer must pulse it, not hold it as a level
cov_in  in  512  16 signed 32-bit entries; entry k = row*4+col at bits [32k+31:32k]
m_valid  out  1  output beat valid
m_ready  in  1  consumer accepts beat when m_valid & m_ready
m_data  out  32  signed entry value
m_idx  out  4  unique-entry index 0..9
m_first  out  1  high on idx 0
m_last  out  1  high on idx 9
m_frame  out  8  frame tag of the streamed bank
overflow  out  1  one-cycle pulse when a frame is dropped
drop_cnt  out  DROP_W  dropped frames, saturates at all-ones

Behaviour:
- Reset values: m_valid=0, m_data=0, m_idx=0, m_first=0, m_last=0, m_frame=0, overflow=0, drop_cnt=0. Both banks empty, frame tag counter=0, reader IDLE.
- Stream order, idx 0..9 maps to k = 0,1,2,3,5,6,7,10,11,15 (R00,R01,R02,R03,R11,R12,R13,R22,R23,R33). The lower triangle of cov_in is ignored.
- Capture on cov_valid=1:
  - Write into a free bank; if both banks are free, use bank 0.
  - Diagonal entries (k=0,5,10,15) become sat32(entry + DIAG_LOAD); all other entries are copied unchanged.
  - sat32 rule: a 33-bit sum above 2^31-1 gives 0x7FFFFFFF; below -2^31 gives 0x80000000.
  - The bank's tag is set to the frame tag counter, which then increments and wraps 255->0.
  - Only accepted frames advance the tag.
- Full condition: both banks occupied at cov_valid.
  - Exception: if the streaming bank's m_last handshake occurs in the same cycle, the capture overwrites that bank and is accepted. No drop is recorded.
  - Otherwise the frame is dropped: overflow=1 for one cycle, drop_cnt increments (saturating), and bank contents and the tag counter are unchanged.
- Reader FSM:
  - IDLE: if a bank is full, select the oldest full bank (FIFO order), then go to STREAM with m_valid=1 and idx=0 on the next cycle.
  - STREAM: on handshake, advance idx. On handshake with idx=9, release the bank. Then either start the next full bank at idx 0 in the following cycle with no bubble (stay in STREAM), or go to IDLE with m_valid=0.
- Latency: cov_valid at cycle N with reader IDLE gives m_valid=1, idx 0 at cycle N+1.
- While m_valid=1 and m_ready=0, m_data, m_idx, m_first, m_last and m_frame hold stable.
- The bank being streamed is never written except via the m_last same-cycle exception above.
- m_ready is ignored when m_valid=0.
- rst mid-stream: all state returns to reset values; partial frames are discarded and no further beats are emitted.

Decomposition:
- Shared package cov_pkg holds:
  - N_CH=4, N_UNIQ=10, ENTRY_W=32.
  - The idx-to-k lookup constant.
  - The sat32 add function; the upstream accumulator and the future eigen stage also use it.
- One sub-module, cov_bank_ctrl: two-bank occupancy, oldest-bank pointer, free-bank select, drop decision.
- Datapath and reader FSM stay in the top.

Test Plan:
- Single frame, DIAG_LOAD=0, cov_in entry k = k*0x100 (entry 0 = 0), m_ready=1 -> beats on cycles N+1..N+10 with data 0x000,0x100,0x200,0x300,0x500,0x600,0x700,0xA00,0xB00,0xF00; first on beat 0, last on beat 9, m_frame=0.
- DIAG_LOAD=0x10, entry 0 = 0x7FFFFFF8, entry 15 = 0x80000000 -> idx0 = 0x7FFFFFFF (saturated), idx9 = 0x80000010, idx4/idx7 equal their input + 0x10.
- m_ready=0 with three strobes 20 cycles apart -> first two frames buffered; third gives overflow pulse and drop_cnt=1. Releasing m_ready streams frame tags 0 then 1 back-to-back with no bubble between idx 9 and idx 0.
- Both banks full, cov_valid in the same cycle as the m_last handshake -> no overflow, drop_cnt unchanged, new frame streamed after the pending bank with tag 2.
- m_ready toggled 1,0,0,1 pseudo-randomly -> m_data/m_idx never change while stalled; all 10 indices are delivered exactly once, in order.
- rst asserted at idx 5 with one bank pending -> next cycle m_valid=0, drop_cnt=0. A following strobe streams with m_frame=0.

Source files
------------

// File: rtl/cov_matrix_streamer_pkg.sv
// Shared definitions for the MUSIC covariance chain: widths, the
// upper-triangle index map and the saturating 32-bit add.
package cov_pkg;

   localparam int N_CH    = 4;
   localparam int N_UNIQ  = 10;
   localparam int ENTRY_W = 32;
   localparam int IDX_W   = 4;
   localparam int TAG_W   = 8;

   // Nibble i holds the flat matrix index k (row*4+col) of unique entry i.
   localparam logic [N_UNIQ*4-1:0] IDX2K = {4'd15, 4'd11, 4'd10, 4'd7, 4'd6,
                                            4'd5,  4'd3,  4'd2,  4'd1, 4'd0};

   typedef logic signed [ENTRY_W-1:0] entry_t;

   typedef enum logic {
      RD_IDLE,
      RD_STREAM
   } rd_state_t;

   function automatic logic [3:0] idx_to_k(input int idx);
      return IDX2K[4*idx +: 4];
   endfunction

   function automatic logic is_diag(input logic [3:0] k);
      return k[1:0] == k[3:2];
   endfunction

   function automatic entry_t sat32(input entry_t a, input entry_t b);
      logic signed [ENTRY_W:0] s;
      s = {a[ENTRY_W-1], a} + {b[ENTRY_W-1], b};
      if (s[ENTRY_W] != s[ENTRY_W-1])
         return s[ENTRY_W] ? {1'b1, {(ENTRY_W-1){1'b0}}} : {1'b0, {(ENTRY_W-1){1'b1}}};
      return s[ENTRY_W-1:0];
   endfunction

endpackage

// File: rtl/cov_matrix_streamer_if.sv
// Valid/ready beat bus from the covariance streamer to the eigen stage.
interface cov_matrix_streamer_if;
   import cov_pkg::*;

   logic               m_valid;
   logic               m_ready;
   logic [ENTRY_W-1:0] m_data;
   logic [IDX_W-1:0]   m_idx;
   logic               m_first;
   logic               m_last;
   logic [TAG_W-1:0]   m_frame;

   modport master (output m_valid, m_data, m_idx, m_first, m_last, m_frame,
                   input  m_ready);
   modport slave  (input  m_valid, m_data, m_idx, m_first, m_last, m_frame,
                   output m_ready);
endinterface

// File: rtl/cov_matrix_streamer_bank_ctrl.sv
// Two-bank occupancy tracking: free-bank select, FIFO ordering of full
// banks, and the drop decision with its saturating counter.
module cov_bank_ctrl #(
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap,
   input  logic              rel,
   input  logic              rd_bank,
   output logic              wr_en,
   output logic              wr_bank,
   output logic              any_n,
   output logic              oldest_n,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);

   logic [1:0] full;
   logic [1:0] full_n;
   logic       last_wr;
   logic       last_wr_n;
   logic       drop;

   always_comb begin
      wr_en   = 1'b0;
      wr_bank = 1'b0;
      drop    = 1'b0;
      if (cap) begin
         if (!(&full)) begin
            wr_en   = 1'b1;
            wr_bank = full[0];
         end else if (rel) begin
            // Bank finishing its last beat this cycle is reused immediately.
            wr_en   = 1'b1;
            wr_bank = rd_bank;
         end else begin
            drop = 1'b1;
         end
      end

      full_n = full;
      if (rel)
         full_n[rd_bank] = 1'b0;
      if (wr_en)
         full_n[wr_bank] = 1'b1;

      last_wr_n = wr_en ? wr_bank : last_wr;
      any_n     = |full_n;
      oldest_n  = (&full_n) ? ~last_wr_n : ~full_n[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= '0;
         last_wr  <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         full     <= full_n;
         last_wr  <= last_wr_n;
         overflow <= drop;
         if (drop && !(&drop_cnt))
            drop_cnt <= drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/cov_matrix_streamer.sv
// Captures 4x4 covariance frames into a two-bank buffer (with diagonal
// loading) and streams the 10 upper-triangular entries per frame.
//
//   state     | meaning
//   RD_IDLE   | no full bank, m_valid low
//   RD_STREAM | presenting beats of bank rd_bank, idx 0..9
module cov_matrix_streamer
   import cov_pkg::*;
#(
   parameter entry_t DIAG_LOAD = '0,
   parameter int     DROP_W    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cov_valid,
   input  logic [N_CH*N_CH*ENTRY_W-1:0] cov_in,
   cov_matrix_streamer_if.master        m,
   output logic                         overflow,
   output logic [DROP_W-1:0]            drop_cnt
);

   rd_state_t        state;
   logic             valid;
   logic             first;
   logic             last;
   logic             rd_bank;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag_cnt;
   logic [TAG_W-1:0] tag [2];
   entry_t           mem [2][N_UNIQ];
   entry_t           cap_val [N_UNIQ];
   logic             hs;
   logic             rel;
   logic             wr_en;
   logic             wr_bank;
   logic             any_n;
   logic             oldest_n;
   logic             unused_lower;

   for (genvar g = 0; g < N_UNIQ; g++) begin : g_cap
      localparam int K    = int'(IDX2K[4*g +: 4]);
      localparam bit DIAG = is_diag(IDX2K[4*g +: 4]);
      assign cap_val[g] = DIAG ? sat32(entry_t'(cov_in[ENTRY_W*K +: ENTRY_W]), DIAG_LOAD)
                               : entry_t'(cov_in[ENTRY_W*K +: ENTRY_W]);
   end

   // Lower-triangle entries mirror the upper triangle and are not stored.
   assign unused_lower = ^{cov_in[4*ENTRY_W +: ENTRY_W],
                           cov_in[8*ENTRY_W +: 2*ENTRY_W],
                           cov_in[12*ENTRY_W +: 3*ENTRY_W]};

   assign hs  = valid & m.m_ready;
   assign rel = hs & last;

   cov_bank_ctrl #(.DROP_W(DROP_W)) u_bank_ctrl (
      .clk      (clk),
      .rst      (rst),
      .cap      (cov_valid),
      .rel      (rel),
      .rd_bank  (rd_bank),
      .wr_en    (wr_en),
      .wr_bank  (wr_bank),
      .any_n    (any_n),
      .oldest_n (oldest_n),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int i = 0; i < N_UNIQ; i++)
            mem[wr_bank][i] <= cap_val[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_cnt <= '0;
         tag[0]  <= '0;
         tag[1]  <= '0;
      end else if (wr_en) begin
         tag[wr_bank] <= tag_cnt;
         tag_cnt      <= tag_cnt + 8'd1;
      end
   end

   // Reader decisions use next-cycle occupancy so a capture or hand-over
   // this cycle is visible on the very next beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RD_IDLE;
         valid   <= 1'b0;
         idx     <= '0;
         first   <= 1'b0;
         last    <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         case (state)
            RD_IDLE: begin
               if (any_n) begin
                  state   <= RD_STREAM;
                  valid   <= 1'b1;
                  idx     <= '0;
                  first   <= 1'b1;
                  last    <= 1'b0;
                  rd_bank <= oldest_n;
               end
            end
            RD_STREAM: begin
               if (hs) begin
                  if (last) begin
                     idx  <= '0;
                     last <= 1'b0;
                     if (any_n) begin
                        rd_bank <= oldest_n;
                        first   <= 1'b1;
                     end else begin
                        state <= RD_IDLE;
                        valid <= 1'b0;
                        first <= 1'b0;
                     end
                  end else begin
                     idx   <= idx + 4'd1;
                     first <= 1'b0;
                     last  <= (idx == 4'd8);
                  end
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

   assign m.m_valid = valid;
   assign m.m_idx   = idx;
   assign m.m_first = first;
   assign m.m_last  = last;
   assign m.m_data  = valid ? mem[rd_bank][idx] : '0;
   assign m.m_frame = valid ? tag[rd_bank] : '0;

endmodule

// File: tb/tb_cov_matrix_streamer.sv
// Directed bench for cov_matrix_streamer: one instance with no diagonal
// loading, one with DIAG_LOAD=0x10 for the saturation cases.
module tb_cov_matrix_streamer;

   logic         clk = 1'b0;
   logic         rst;
   logic         cv_a, cv_b;
   logic [511:0] cin_a, cin_b;
   logic         ovf_a, ovf_b;
   logic [15:0]  drop_a, drop_b;

   always #5 clk = ~clk;

   cov_matrix_streamer_if sa ();
   cov_matrix_streamer_if sb ();

   cov_matrix_streamer #(.DIAG_LOAD(32'sh0), .DROP_W(16)) dut_a (
      .clk(clk), .rst(rst), .cov_valid(cv_a), .cov_in(cin_a), .m(sa),
      .overflow(ovf_a), .drop_cnt(drop_a));

   cov_matrix_streamer #(.DIAG_LOAD(32'sh10), .DROP_W(16)) dut_b (
      .clk(clk), .rst(rst), .cov_valid(cv_b), .cov_in(cin_b), .m(sb),
      .overflow(ovf_b), .drop_cnt(drop_b));

   typedef struct {
      logic        rdy;
      logic [3:0]  idx;
      logic [31:0] data;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          kmap [10];
   vec_t        t1 [10];
   logic [31:0] t2 [10];
   logic        rdy_pat [24];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ent(input int sel, input int k);
      case (sel)
         1:       return 32'(k * 256);
         2:       return 32'(32'h1000 + k);
         default: return 32'(32'h30000 + k * 3);
      endcase
   endfunction

   function automatic logic [511:0] pat(input int sel);
      logic [511:0] v;
      for (int k = 0; k < 16; k++)
         v[32*k +: 32] = ent(sel, k);
      return v;
   endfunction

   task automatic expect_beat(input string nm, input int i, input logic [31:0] edata,
                              input logic [7:0] eframe);
      logic [3:0] ei;
      ei = 4'(i);
      chk(nm, {17'b0, sa.m_valid, sa.m_idx, sa.m_first, sa.m_last, sa.m_frame, sa.m_data},
              {17'b0, 1'b1, ei, (i == 0), (i == 9), eframe, edata});
   endtask

   task automatic stream_frame(input string nm, input int sel, input logic [7:0] fr);
      for (int i = 0; i < 10; i++) begin
         sa.m_ready = 1'b1;
         expect_beat(nm, i, ent(sel, kmap[i]), fr);
         tick();
      end
   endtask

   task automatic check_idle(input string nm);
      chk(nm, {63'b0, sa.m_valid}, 64'd0);
   endtask

   task automatic check_drop(input string nm, input logic ovf, input logic [15:0] cnt);
      chk(nm, {47'b0, ovf_a, drop_a}, {47'b0, ovf, cnt});
   endtask

   task automatic strobe_a(input int sel);
      cin_a = pat(sel);
      cv_a  = 1'b1;
      tick();
      cv_a  = 1'b0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      cv_a        = 1'b0;
      cv_b        = 1'b0;
      sa.m_ready  = 1'b0;
      sb.m_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int got;
      logic rdy;
      logic [3:0] ii;

      kmap = '{0, 1, 2, 3, 5, 6, 7, 10, 11, 15};
      t1[0] = '{1'b1, 4'd0, 32'h000};
      t1[1] = '{1'b1, 4'd1, 32'h100};
      t1[2] = '{1'b1, 4'd2, 32'h200};
      t1[3] = '{1'b1, 4'd3, 32'h300};
      t1[4] = '{1'b1, 4'd4, 32'h500};
      t1[5] = '{1'b1, 4'd5, 32'h600};
      t1[6] = '{1'b1, 4'd6, 32'h700};
      t1[7] = '{1'b1, 4'd7, 32'hA00};
      t1[8] = '{1'b1, 4'd8, 32'hB00};
      t1[9] = '{1'b1, 4'd9, 32'hF00};
      t2 = '{32'h7FFFFFFF, 32'h11, 32'h22, 32'h33, 32'h1244,
             32'h66, 32'h77, 32'hFFFFFFF0, 32'hBB, 32'h80000010};
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      cin_a = '0;
      cin_b = '0;

      // Reset state
      do_reset();
      chk("reset", {sa.m_valid, sa.m_idx, sa.m_first, sa.m_last, sa.m_frame, sa.m_data,
                    ovf_a, drop_a},
                   64'd0);

      // Single frame, first beat one cycle after the strobe
      strobe_a(1);
      for (int i = 0; i < 10; i++) begin
         sa.m_ready = t1[i].rdy;
         chk("t1_beat", {17'b0, sa.m_valid, sa.m_idx, sa.m_first, sa.m_last, sa.m_frame, sa.m_data},
                        {17'b0, 1'b1, t1[i].idx, (t1[i].idx == 4'd0), (t1[i].idx == 4'd9),
                         8'd0, t1[i].data});
         tick();
      end
      check_idle("t1_idle");

      // Diagonal loading with saturation; lower triangle holds junk
      for (int k = 0; k < 16; k++)
         cin_b[32*k +: 32] = 32'hDEAD0000 | 32'(k);
      cin_b[0*32 +: 32]  = 32'h7FFFFFF8;
      cin_b[1*32 +: 32]  = 32'h11;
      cin_b[2*32 +: 32]  = 32'h22;
      cin_b[3*32 +: 32]  = 32'h33;
      cin_b[5*32 +: 32]  = 32'h1234;
      cin_b[6*32 +: 32]  = 32'h66;
      cin_b[7*32 +: 32]  = 32'h77;
      cin_b[10*32 +: 32] = 32'hFFFFFFE0;
      cin_b[11*32 +: 32] = 32'hBB;
      cin_b[15*32 +: 32] = 32'h80000000;
      sb.m_ready = 1'b1;
      cv_b = 1'b1;
      tick();
      cv_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ii = 4'(i);
         chk("t2_diag", {27'b0, sb.m_valid, sb.m_idx, sb.m_data}, {27'b0, 1'b1, ii, t2[i]});
         tick();
      end
      chk("t2_idle", {63'b0, sb.m_valid}, 64'd0);

      // Back-pressure: two frames buffered, third dropped, then no-bubble drain
      do_reset();
      strobe_a(1);
      repeat (19) tick();
      strobe_a(2);
      repeat (19) tick();
      strobe_a(3);
      check_drop("t3_ovf", 1'b1, 16'd1);
      expect_beat("t3_hold", 0, ent(1, 0), 8'd0);
      tick();
      check_drop("t3_ovf_end", 1'b0, 16'd1);
      stream_frame("t3_f0", 1, 8'd0);
      stream_frame("t3_f1", 2, 8'd1);
      check_idle("t3_idle");

      // Capture coinciding with the m_last handshake while both banks are full
      do_reset();
      strobe_a(1);
      tick();
      strobe_a(2);
      tick();
      for (int i = 0; i < 10; i++) begin
         sa.m_ready = 1'b1;
         if (i == 9) begin
            cin_a = pat(3);
            cv_a  = 1'b1;
         end
         expect_beat("t4_f0", i, ent(1, kmap[i]), 8'd0);
         tick();
         cv_a = 1'b0;
      end
      check_drop("t4_nodrop", 1'b0, 16'd0);
      stream_frame("t4_f1", 2, 8'd1);
      stream_frame("t4_f2", 3, 8'd2);
      check_idle("t4_idle");

      // Irregular m_ready: outputs hold while stalled, every index once in order
      do_reset();
      strobe_a(2);
      got = 0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         if (got < 10) begin
            rdy = (cyc < 24) ? rdy_pat[cyc] : 1'b1;
            sa.m_ready = rdy;
            expect_beat("t5_stall", got, ent(2, kmap[got]), 8'd0);
            if (rdy)
               got++;
            tick();
         end
      end
      check_idle("t5_idle");

      // Reset in the middle of a frame with another bank pending and a drop recorded
      do_reset();
      strobe_a(1);
      tick();
      strobe_a(2);
      tick();
      strobe_a(3);
      check_drop("t6_drop", 1'b1, 16'd1);
      for (int i = 0; i < 5; i++) begin
         sa.m_ready = 1'b1;
         expect_beat("t6_pre", i, ent(1, kmap[i]), 8'd0);
         tick();
      end
      expect_beat("t6_idx5", 5, ent(1, kmap[5]), 8'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst", {43'b0, sa.m_valid, sa.m_idx, ovf_a, drop_a}, 64'd0);
      tick();
      tick();
      check_idle("t6_quiet");
      strobe_a(3);
      stream_frame("t6_after", 3, 8'd0);
      check_idle("t6_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
